alu_serial: RTL

Parametrised digit-serial ALU that processes WIDTH-bit operands DIGIT bits per clock, starting at the LSB, through a chain of conditioned full-adder slices. It replaces the single-bit combinational adder slice with a self-sequencing unit. The unit has a valid/ready handshake on both sides, registered status flags, and a persistent carry for multi-word arithmetic. It sits between the operand register file and the writeback stage.

---
 rtl/alu_pkg.sv | 100 ++++++++++
 rtl/alu_digit.sv | 41 ++++
 rtl/alu_serial.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the digit-serial ALU.
// Holds the opsel encoding, the controller state encoding and the decode
// function that maps an opsel to its b-conditioning and carry-in source.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_INC   = 3'b010,
    ALU_CMP   = 3'b011,
    ALU_ADC   = 3'b100,
    ALU_PASSA = 3'b101,
    ALU_SBB   = 3'b110,
    ALU_RSVD  = 3'b111
  } opsel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // How operand B is presented to the adder slices
  typedef enum logic [1:0] {
    BSEL_PASS = 2'd0,
    BSEL_INV  = 2'd1,
    BSEL_ZERO = 2'd2
  } bsel_e;

  // Where the initial digit carry comes from
  typedef enum logic [1:0] {
    CIN_ZERO = 2'd0,
    CIN_ONE  = 2'd1,
    CIN_CREG = 2'd2
  } cinsel_e;

  typedef struct packed {
    bsel_e   bsel;
    cinsel_e cinsel;
    logic    rsvd;
    logic    cmp;
    logic    passa;
  } op_ctrl_t;

  // Without the carry chain, ADC and SBB have no carry source and are
  // folded into the reserved group.
  function automatic op_ctrl_t decode_op(input opsel_e op, input logic carry_chain_en);
    op_ctrl_t c;
    c.bsel   = BSEL_PASS;
    c.cinsel = CIN_ZERO;
    c.rsvd   = 1'b0;
    c.cmp    = 1'b0;
    c.passa  = 1'b0;
    case (op)
      ALU_ADD: begin
        c.bsel   = BSEL_PASS;
        c.cinsel = CIN_ZERO;
      end
      ALU_SUB: begin
        c.bsel   = BSEL_INV;
        c.cinsel = CIN_ONE;
      end
      ALU_INC: begin
        c.bsel   = BSEL_ZERO;
        c.cinsel = CIN_ONE;
      end
      ALU_CMP: begin
        c.bsel   = BSEL_INV;
        c.cinsel = CIN_ONE;
        c.cmp    = 1'b1;
      end
      ALU_ADC: begin
        if (carry_chain_en) begin
          c.bsel   = BSEL_PASS;
          c.cinsel = CIN_CREG;
        end else begin
          c.rsvd = 1'b1;
        end
      end
      ALU_PASSA: begin
        c.bsel   = BSEL_ZERO;
        c.cinsel = CIN_ZERO;
        c.passa  = 1'b1;
      end
      ALU_SBB: begin
        if (carry_chain_en) begin
          c.bsel   = BSEL_INV;
          c.cinsel = CIN_CREG;
        end else begin
          c.rsvd = 1'b1;
        end
      end
      default: begin
        c.rsvd = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_digit.sv
// alu_digit: combinational DIGIT-bit slice of the serial ALU.
// Conditions operand B, ripples DIGIT full adders and exposes the sum digit,
// the carry out of the top bit and the carry into the top bit (for overflow).
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic [1:0]       bsel,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT-1:0] b_cond;
  logic [DIGIT:0]   rip;

  // Condition B, then ripple the carry through the full-adder chain
  always_comb begin
    b_cond = b_dig;
    sum    = '0;
    rip    = '0;
    case (bsel)
      BSEL_INV:  b_cond = ~b_dig;
      BSEL_ZERO: b_cond = '0;
      default:   b_cond = b_dig;
    endcase
    rip[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a_dig[i] ^ b_cond[i] ^ rip[i];
      rip[i+1] = (a_dig[i] & b_cond[i]) | (rip[i] & (a_dig[i] ^ b_cond[i]));
    end
  end

  assign cout  = rip[DIGIT];
  assign c_msb = rip[DIGIT-1];

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU, WIDTH-bit operands processed DIGIT bits per
// clock starting at the LSB, with valid/ready on both sides, registered flags
// and a persistent carry for multi-word arithmetic.
// Optional feature macro: ALU_SERIAL_CARRY_CHAIN_EN enables the persistent
// carry register and the ADC/SBB operations; without it they act as reserved.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opsel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             err
);

  localparam int K     = WIDTH / DIGIT;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

`ifdef ALU_SERIAL_CARRY_CHAIN_EN
  localparam logic CARRY_CHAIN = 1'b1;
`else
  localparam logic CARRY_CHAIN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  bsel_e              bsel_q, bsel_d;
  logic               rsvd_q, rsvd_d;
  logic               cmp_q, cmp_d;
  logic               passa_q, passa_d;
  logic               carry_q, carry_d;
  logic               zacc_q, zacc_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_n_q, flag_n_d;
  logic               flag_v_q, flag_v_d;
  logic               err_q, err_d;
  logic               c_reg_val;

`ifdef ALU_SERIAL_CARRY_CHAIN_EN
  logic               c_reg_q, c_reg_d;
  assign c_reg_val = c_reg_q;
`else
  assign c_reg_val = 1'b0;
`endif

  op_ctrl_t           accept_ctrl;
  logic [DIGIT-1:0]   dig_sum;
  logic               dig_cout;
  logic               dig_cmsb;
  logic               digit_zero;
  logic [WIDTH-1:0]   shreg_next;

  assign accept_ctrl = decode_op(opsel_e'(opsel), CARRY_CHAIN);

  alu_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a_dig (a_sh_q[DIGIT-1:0]),
    .b_dig (b_sh_q[DIGIT-1:0]),
    .bsel  (bsel_q),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  assign digit_zero = (dig_sum == '0);
  assign shreg_next = (shreg_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  // Sequencer: accept in IDLE, one digit per cycle in BUSY, hold in DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    bsel_d   = bsel_q;
    rsvd_d   = rsvd_q;
    cmp_d    = cmp_q;
    passa_d  = passa_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    shreg_d  = shreg_q;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    err_d    = err_q;
`ifdef ALU_SERIAL_CARRY_CHAIN_EN
    c_reg_d  = c_reg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          a_sh_d  = a;
          b_sh_d  = b;
          bsel_d  = accept_ctrl.bsel;
          rsvd_d  = accept_ctrl.rsvd;
          cmp_d   = accept_ctrl.cmp;
          passa_d = accept_ctrl.passa;
          cnt_d   = '0;
          zacc_d  = 1'b1;
          err_d   = accept_ctrl.rsvd;
          case (accept_ctrl.cinsel)
            CIN_ONE:  carry_d = 1'b1;
            CIN_CREG: carry_d = c_reg_val;
            default:  carry_d = 1'b0;
          endcase
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        shreg_d = shreg_next;
        carry_d = dig_cout;
        zacc_d  = zacc_q & digit_zero;
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(K - 1)) begin
          state_d = S_DONE;
          if (rsvd_q) begin
            result_d = '0;
          end else begin
            result_d = cmp_q ? a_q : shreg_next;
            flag_c_d = passa_q ? 1'b0 : dig_cout;
            flag_z_d = zacc_q & digit_zero;
            flag_n_d = dig_sum[DIGIT-1];
            flag_v_d = passa_q ? 1'b0 : (dig_cmsb ^ dig_cout);
`ifdef ALU_SERIAL_CARRY_CHAIN_EN
            c_reg_d  = passa_q ? 1'b0 : dig_cout;
`endif
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register update; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      bsel_q   <= BSEL_PASS;
      rsvd_q   <= 1'b0;
      cmp_q    <= 1'b0;
      passa_q  <= 1'b0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      shreg_q  <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_v_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SERIAL_CARRY_CHAIN_EN
      c_reg_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      bsel_q   <= bsel_d;
      rsvd_q   <= rsvd_d;
      cmp_q    <= cmp_d;
      passa_q  <= passa_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      shreg_q  <= shreg_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_v_q <= flag_v_d;
      err_q    <= err_d;
`ifdef ALU_SERIAL_CARRY_CHAIN_EN
      c_reg_q  <= c_reg_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_v    = flag_v_q;
  assign err       = err_q;

endmodule
